// File: rtl/dac_update_scheduler.sv
// ---------------------------------------------------------------------------
// dac_update_scheduler
//
// Purpose:
//   Paces DAC updates at a fixed slot rate derived from clk_1MHz. In each
//   slot it picks either the DDS wave sample or a pending one-shot override,
//   clamps the code to CODE_MAX and hands it to the SPI DAC transmitter
//   through a dac_start / dac_busy handshake. Slots that cannot be serviced
//   are dropped and counted in a saturating overrun counter.
//
// Handshake:
//   dac_start is a one-cycle pulse and dac_value is stable whenever it is
//   high. The transmitter raises dac_busy while its frame is in flight. A
//   transfer is finished when dac_busy returns low after having been seen
//   high. If dac_busy never rises within 4 cycles of the pulse, the
//   handshake is considered lost. The override side is a level request
//   (ovr_req, with ovr_value held stable) acknowledged by a single ovr_ack
//   pulse, which is always coincident with dac_start.
//
// Ports:
//   clk_1MHz     system clock, rising edge
//   rst          synchronous active-high reset
//   enable       1 runs the slot counter, 0 holds it at 0 (no slots)
//   wave_value   DDS sample, sampled in slot cycles only
//   ovr_req      override request level, held until ovr_ack
//   ovr_value    override code
//   ovr_ack      one-cycle pulse when the override code is issued
//   dac_busy     transmitter frame in flight
//   dac_value    registered code presented to the transmitter
//   dac_start    one-cycle start pulse to the transmitter
//   src_sel      source of last issued code (0 wave, 1 override)
//   sample_tick  high in the slot cycle
//   cnt_clr      synchronous clear of overrun_cnt (wins over increment)
//   overrun_cnt  saturating count of dropped slots / lost handshakes
//   dbg_state    FSM state: 0 IDLE, 1 ACCEPT, 2 XFER
// ---------------------------------------------------------------------------
module dac_update_scheduler #(
  parameter int unsigned SAMPLE_DIV = 20,
  parameter logic [11:0] CODE_MAX   = 12'd4095
) (
  input  logic        clk_1MHz,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] wave_value,
  input  logic        ovr_req,
  input  logic [11:0] ovr_value,
  output logic        ovr_ack,
  input  logic        dac_busy,
  output logic [11:0] dac_value,
  output logic        dac_start,
  output logic        src_sel,
  output logic        sample_tick,
  input  logic        cnt_clr,
  output logic [7:0]  overrun_cnt,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_XFER   = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [1:0]  r_wait;
  logic [11:0] r_dac_value;
  logic        r_dac_start;
  logic        r_ovr_ack;
  logic        r_src_sel;
  logic [7:0]  r_overrun;

  logic        w_tick;
  logic [11:0] w_raw;
  logic [11:0] w_code;
  logic        w_issue;
  logic        w_drop;
  logic        w_timeout;

  // Slot counter: free-running modulo SAMPLE_DIV while enabled.
  always_ff @(posedge clk_1MHz) begin
    if (rst || !enable) begin
      r_cnt <= '0;
    end else if (r_cnt == DIV_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign w_tick = (r_cnt == DIV_LAST) && enable;

  assign w_raw  = ovr_req ? ovr_value : wave_value;
  assign w_code = (w_raw > CODE_MAX) ? CODE_MAX : w_raw;

  // A slot is serviced from IDLE, or from XFER when the transmitter
  // releases busy in the very slot cycle. Otherwise the slot is lost.
  assign w_issue   = w_tick && ((r_state == ST_IDLE) ||
                                ((r_state == ST_XFER) && !dac_busy));
  assign w_drop    = w_tick && ((r_state == ST_ACCEPT) ||
                                ((r_state == ST_XFER) && dac_busy));
  assign w_timeout = (r_state == ST_ACCEPT) && !dac_busy && (r_wait == 2'd3);

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_dac_value <= '0;
      r_dac_start <= 1'b0;
      r_ovr_ack   <= 1'b0;
      r_src_sel   <= 1'b0;
    end else begin
      r_dac_start <= 1'b0;
      r_ovr_ack   <= 1'b0;
      if (w_issue) begin
        r_dac_value <= w_code;
        r_src_sel   <= ovr_req;
        r_dac_start <= 1'b1;
        r_ovr_ack   <= ovr_req;
        r_wait      <= '0;
        r_state     <= ST_ACCEPT;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_ACCEPT: begin
            if (dac_busy) begin
              r_state <= ST_XFER;
            end else if (r_wait == 2'd3) begin
              // Four cycles without busy: the handshake was lost.
              r_state <= ST_IDLE;
            end else begin
              r_wait <= r_wait + 2'd1;
            end
          end
          ST_XFER: begin
            if (!dac_busy) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst || cnt_clr) begin
      r_overrun <= '0;
    end else if ((w_drop || w_timeout) && (r_overrun != 8'hFF)) begin
      r_overrun <= r_overrun + 8'd1;
    end
  end

  assign sample_tick = w_tick;
  assign dac_value   = r_dac_value;
  assign dac_start   = r_dac_start;
  assign ovr_ack     = r_ovr_ack;
  assign src_sel     = r_src_sel;
  assign overrun_cnt = r_overrun;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_dac_update_scheduler.sv
module tb_dac_update_scheduler;

  localparam int          DIV  = 20;
  localparam logic [11:0] CMAX = 12'd3312;
  localparam int          W    = 46;  // {cycle[31:0], ack, src, code[11:0]}

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [11:0] wave_value = '0;
  logic        ovr_req = 1'b0;
  logic [11:0] ovr_value = '0;
  logic        ovr_ack;
  logic        dac_busy;
  logic [11:0] dac_value;
  logic        dac_start;
  logic        src_sel;
  logic        sample_tick;
  logic        cnt_clr = 1'b0;
  logic [7:0]  overrun_cnt;
  logic [1:0]  dbg_state;

  dac_update_scheduler #(.SAMPLE_DIV(DIV), .CODE_MAX(CMAX)) dut (
    .clk_1MHz   (clk),
    .rst        (rst),
    .enable     (enable),
    .wave_value (wave_value),
    .ovr_req    (ovr_req),
    .ovr_value  (ovr_value),
    .ovr_ack    (ovr_ack),
    .dac_busy   (dac_busy),
    .dac_value  (dac_value),
    .dac_start  (dac_start),
    .src_sel    (src_sel),
    .sample_tick(sample_tick),
    .cnt_clr    (cnt_clr),
    .overrun_cnt(overrun_cnt),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int base     = 0;
  int tick_cnt = 0;

  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // transmitter model: latches on dac_start, busy for tx_len cycles
  int tx_len   = 17;
  bit tx_dead  = 1'b0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (dac_start && !tx_dead) busy_cnt <= tx_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign dac_busy = (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc - base);
    end
  endtask

  task automatic push_exp(input int c, input logic ack, input logic src, input logic [11:0] code);
    exp_q.push_back({32'(c), ack, src, code});
  endtask

  // scoreboard: every start pulse pops one expected issue
  logic [W-1:0] mon_e;
  logic         prev_start = 1'b0;
  always @(negedge clk) begin
    if (sample_tick) tick_cnt++;
    if (!rst) begin
      if (ovr_ack && !dac_start) check("ack_without_start", 32'(ovr_ack), 32'd0);
      if (dac_start) begin
        if (prev_start) check("start_twice", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          check("spurious_start", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("start_cycle", 32'(cyc - base), mon_e[45:14]);
          check("ovr_ack", 32'(ovr_ack), 32'(mon_e[13]));
          check("src_sel", 32'(src_sel), 32'(mon_e[12]));
          check("dac_value", 32'(dac_value), 32'(mon_e[11:0]));
        end
      end
    end
    prev_start <= dac_start;
  end

  // driver tasks
  task automatic run_to(input int t);
    while (cyc - base < t) begin
      @(negedge clk);
      if (ovr_ack) ovr_req = 1'b0;  // requester drops on ack
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    rst  = 1'b0;
    base = cyc;  // this cycle is cycle 0 out of reset
  endtask

  task automatic check_q_empty(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  int t0;

  initial begin
    // --- basic pacing ---
    wave_value = 12'h123; tx_len = 17; tx_dead = 1'b0;
    do_reset();
    check("rst_dac_value", 32'(dac_value), 32'd0);
    check("rst_dac_start", 32'(dac_start), 32'd0);
    check("rst_ovr_ack", 32'(ovr_ack), 32'd0);
    check("rst_src_sel", 32'(src_sel), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    check("rst_tick", 32'(sample_tick), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    push_exp(20, 0, 0, 12'h123);
    push_exp(40, 0, 0, 12'h123);
    push_exp(60, 0, 0, 12'h123);
    run_to(18); check("tick_early", 32'(sample_tick), 32'd0);
    run_to(19); check("tick_first", 32'(sample_tick), 32'd1);
    run_to(30);
    check("hold_value", 32'(dac_value), 32'h123);
    check("state_xfer", 32'(dbg_state), 32'd2);
    run_to(65);
    check("basic_overrun", 32'(overrun_cnt), 32'd0);
    check_q_empty("basic_q");

    // --- override one-shot ---
    wave_value = 12'h123; ovr_value = 12'hABC; ovr_req = 1'b1;
    do_reset();
    push_exp(20, 1, 1, 12'hABC);
    push_exp(40, 0, 0, 12'h123);
    run_to(30); check("ovr_src_hold", 32'(src_sel), 32'd1);
    run_to(45); check("ovr_back_wave", 32'(src_sel), 32'd0);
    check_q_empty("ovr_q");

    // --- clamp ---
    ovr_req = 1'b0; wave_value = 12'd4000;
    do_reset();
    push_exp(20, 0, 0, CMAX);
    push_exp(40, 0, 0, CMAX);
    push_exp(60, 0, 0, 12'd0);
    run_to(25); wave_value = 12'd3312;
    run_to(45); wave_value = 12'd0;
    run_to(65);
    check_q_empty("clamp_q");

    // --- slow transmitter, override pending across a dropped slot ---
    wave_value = 12'h321; tx_len = 25;
    do_reset();
    push_exp(20, 0, 0, 12'h321);
    push_exp(60, 1, 1, 12'h5A5);
    push_exp(100, 0, 0, 12'h321);
    run_to(30); ovr_value = 12'h5A5; ovr_req = 1'b1;
    run_to(39); check("slow_tick_busy", 32'({sample_tick, dac_busy}), 32'd3);
    run_to(40); check("slow_overrun1", 32'(overrun_cnt), 32'd1);
    run_to(45); check("ovr_still_pending", 32'(ovr_req), 32'd1);
    run_to(105);
    check("slow_overrun2", 32'(overrun_cnt), 32'd2);
    check_q_empty("slow_q");

    // --- busy falls in the slot cycle ---
    wave_value = 12'h0F0; tx_len = 18;
    do_reset();
    push_exp(20, 0, 0, 12'h0F0);
    push_exp(40, 0, 0, 12'h0F0);
    push_exp(60, 0, 0, 12'h0F0);
    run_to(39); check("edge_busy_low", 32'({sample_tick, dac_busy, dbg_state}), 32'b1010);
    run_to(65);
    check("edge_overrun", 32'(overrun_cnt), 32'd0);
    check_q_empty("edge_q");

    // --- transmitter never busy: timeouts, saturation, clear ---
    wave_value = 12'h777; tx_dead = 1'b1;
    do_reset();
    for (int i = 1; i <= 302; i++) push_exp(20 * i, 0, 0, 12'h777);
    run_to(23);
    check("to_before", 32'(overrun_cnt), 32'd0);
    check("to_accept", 32'(dbg_state), 32'd1);
    run_to(24);
    check("to_after", 32'(overrun_cnt), 32'd1);
    check("to_idle", 32'(dbg_state), 32'd0);
    run_to(20 * 300 + 10);
    check("saturate", 32'(overrun_cnt), 32'd255);
    run_to(20 * 301 + 3); cnt_clr = 1'b1;
    run_to(20 * 301 + 4); cnt_clr = 1'b0;
    check("clr_wins", 32'(overrun_cnt), 32'd0);
    run_to(20 * 302 + 4);
    check("after_clr", 32'(overrun_cnt), 32'd1);
    check_q_empty("dead_q");
    tx_dead = 1'b0;

    // --- reset during transfer ---
    wave_value = 12'h456; tx_len = 17;
    do_reset();
    push_exp(20, 0, 0, 12'h456);
    run_to(25); check("pre_rst_state", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    run_to(26);
    check("mid_rst_outputs", 32'({dac_value, dac_start, ovr_ack, src_sel, overrun_cnt, sample_tick, dac_busy}), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0; base = cyc;
    push_exp(20, 0, 0, 12'h456);

    // --- enable low for 50 cycles ---
    run_to(25);
    enable = 1'b0;
    t0 = tick_cnt;
    run_to(75);
    check("dis_no_tick", 32'(tick_cnt - t0), 32'd0);
    check("dis_xfer_done", 32'(dbg_state), 32'd0);
    enable = 1'b1;  // cycle 75 counts as cycle 0 of the re-enabled run
    push_exp(95, 0, 0, 12'h456);
    run_to(93); check("reen_tick_early", 32'(sample_tick), 32'd0);
    run_to(94); check("reen_tick", 32'(sample_tick), 32'd1);
    run_to(100);
    check_q_empty("reen_q");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
